// File: rtl/wbpport_gen_pkg.sv
// Shared definitions for the Wishbone parallel-port peripheral:
// register addresses, control bit positions, bus request bundle.
package wbpport_gen_pkg;

    localparam logic [1:0] PP_SETUP = 2'd0;
    localparam logic [1:0] PP_FIFO  = 2'd1;
    localparam logic [1:0] PP_RX    = 2'd2;
    localparam logic [1:0] PP_TX    = 2'd3;

    localparam int RST_BIT    = 16;
    localparam int CLROVF_BIT = 19;

    // Bus request captured on stb, acted upon one clock later.
    typedef struct packed {
        logic        we;
        logic [1:0]  addr;
        logic        rst;
        logic        clrovf;
        logic [15:0] data;
    } wb_req_t;

    function automatic int clamp_lg(input int lg);
        if (lg < 2) return 2;
        if (lg > 10) return 10;
        return lg;
    endfunction

    function automatic logic [15:0] fifo_stat(
        input logic [3:0] lg,
        input logic [9:0] fill,
        input logic       half,
        input logic       flag
    );
        return {lg, fill, half, flag};
    endfunction

endpackage

// File: rtl/wbpport_gen_if.sv
// Wishbone classic-pipelined bus bundle for the parallel port.
// master drives cyc/stb/we/addr/wdata; slave returns ack/stall/rdata.
interface wbpport_gen_if;

    logic        cyc;
    logic        stb;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        ack;
    logic        stall;
    logic [31:0] rdata;

    modport master (
        output cyc, stb, we, addr, wdata,
        input  ack, stall, rdata
    );

    modport slave (
        input  cyc, stb, we, addr, wdata,
        output ack, stall, rdata
    );

endinterface

// File: rtl/pp_sfifo.sv
// Synchronous first-word-fall-through FIFO, 2^LGFLEN deep.
// Ports: push/pop/din in; head/fill/full/empty out; sync rst and clr.
module pp_sfifo #(
    parameter int BW     = 8,
    parameter int LGFLEN = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [BW-1:0]     i_din,
    output logic [BW-1:0]     o_head,
    output logic [LGFLEN:0]   o_fill,
    output logic              o_full,
    output logic              o_empty
);

    localparam int DEPTH = 1 << LGFLEN;
    localparam int FW    = LGFLEN + 1;
    localparam logic [FW-1:0] FULLV = FW'(DEPTH);

    logic [BW-1:0]     mem_q [DEPTH];
    logic [LGFLEN-1:0] wp_q, wp_d;
    logic [LGFLEN-1:0] rp_q, rp_d;
    logic [FW-1:0]     fill_q, fill_d;
    logic              push_ok;
    logic              pop_ok;

    assign o_empty = (fill_q == '0);
    assign o_full  = (fill_q == FULLV);
    assign o_fill  = fill_q;

    // A push into a full FIFO succeeds only alongside a pop.
    assign pop_ok  = i_pop && !o_empty;
    assign push_ok = i_push && (!o_full || pop_ok);

    assign o_head = o_empty ? '0 : mem_q[rp_q];

    always_comb begin
        wp_d   = wp_q;
        rp_d   = rp_q;
        fill_d = fill_q + FW'(push_ok) - FW'(pop_ok);
        if (push_ok) wp_d = wp_q + LGFLEN'(1);
        if (pop_ok)  rp_d = rp_q + LGFLEN'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            wp_q   <= '0;
            rp_q   <= '0;
            fill_q <= '0;
        end else begin
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            fill_q <= fill_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok && !i_clr && !i_rst)
            mem_q[wp_q] <= i_din;
    end

endmodule

// File: rtl/wbpport_gen.sv
// Wishbone parallel-port peripheral with RX/TX FIFOs, overflow flags
// and RX idle timeout. Ports: wb bus (slave), pp RX/TX link, interrupts.
module wbpport_gen
    import wbpport_gen_pkg::*;
#(
    parameter int DW     = 8,
    parameter int LGFLEN = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    wbpport_gen_if.slave  wb,
    input  logic          i_pp_stb,
    input  logic [DW-1:0] i_pp_data,
    output logic          o_pp_busy,
    output logic          o_pp_stb,
    output logic [DW-1:0] o_pp_data,
    input  logic          i_pp_busy,
    output logic          o_rx_int,
    output logic          o_tx_int,
    output logic          o_rxfifo_int,
    output logic          o_txfifo_int,
    output logic          o_rxto_int
);

    localparam int LGF = clamp_lg(LGFLEN);
    localparam int FW  = LGF + 1;
    localparam logic [FW-1:0] HALF = FW'(1 << (LGF - 1));
    localparam logic [3:0]    LG4  = 4'(LGF);
    localparam logic [4:0]    DWM1 = 5'(DW - 1);

    logic          r_ack_q;
    logic          ack_q;
    wb_req_t       req_q, req_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [15:0]   tmo_q, tmo_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          rxovf_q, rxovf_d;
    logic          txovf_q, txovf_d;

    logic          stb;
    logic          act;
    logic          su_wr, rx_wr, tx_wr;
    logic          rx_clr, tx_clr;
    logic          rx_pop, tx_pop, tx_push;
    logic          rx_drop, tx_drop, rx_push_ok;

    logic [DW-1:0] rx_head, tx_head;
    logic [FW-1:0] rx_fill, tx_fill;
    logic [9:0]    rx_fill10, tx_fill10;
    logic          rx_full, rx_empty, tx_full, tx_empty;
    logic          rx_half, tx_half;
    logic          unused_wdata;

    assign unused_wdata = ^{wb.wdata[31:20], wb.wdata[18:17]};

    assign stb = wb.cyc && wb.stb;
    // Side effects happen one clock after stb, alongside data capture.
    assign act = r_ack_q && !i_rst;

    assign su_wr = act && req_q.we && (req_q.addr == PP_SETUP);
    assign rx_wr = act && req_q.we && (req_q.addr == PP_RX);
    assign tx_wr = act && req_q.we && (req_q.addr == PP_TX);

    assign rx_clr  = su_wr || (rx_wr && req_q.rst);
    assign tx_clr  = su_wr || (tx_wr && req_q.rst);
    assign tx_push = tx_wr && !req_q.rst;

    assign rx_pop = act && !req_q.we && (req_q.addr == PP_RX) && !rx_empty;
    assign tx_pop = !tx_empty && !i_pp_busy;

    // A word discarded by a FIFO clear is not an overflow.
    assign rx_drop    = i_pp_stb && rx_full && !rx_pop && !rx_clr;
    assign rx_push_ok = i_pp_stb && (!rx_full || rx_pop) && !rx_clr;
    assign tx_drop    = tx_push && tx_full && !tx_pop;

    pp_sfifo #(.BW(DW), .LGFLEN(LGF)) u_rx (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (rx_clr),
        .i_push  (i_pp_stb),
        .i_pop   (rx_pop),
        .i_din   (i_pp_data),
        .o_head  (rx_head),
        .o_fill  (rx_fill),
        .o_full  (rx_full),
        .o_empty (rx_empty)
    );

    pp_sfifo #(.BW(DW), .LGFLEN(LGF)) u_tx (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (tx_clr),
        .i_push  (tx_push),
        .i_pop   (tx_pop),
        .i_din   (req_q.data[DW-1:0]),
        .o_head  (tx_head),
        .o_fill  (tx_fill),
        .o_full  (tx_full),
        .o_empty (tx_empty)
    );

    assign rx_fill10 = 10'(rx_fill);
    assign tx_fill10 = 10'(tx_fill);
    assign rx_half   = (rx_fill >= HALF);
    assign tx_half   = (tx_fill < HALF);

    always_comb begin
        req_d = req_q;
        if (stb) begin
            req_d.we     = wb.we;
            req_d.addr   = wb.addr;
            req_d.rst    = wb.wdata[RST_BIT];
            req_d.clrovf = wb.wdata[CLROVF_BIT];
            req_d.data   = wb.wdata[15:0];
        end
    end

    // Read data reflects state before this clock's side effects.
    always_comb begin
        rdata_d = rdata_q;
        if (act) begin
            unique case (req_q.addr)
                PP_SETUP: rdata_d = {LG4, 7'h0, DWM1, tmo_q};
                PP_FIFO:  rdata_d = {
                    fifo_stat(LG4, tx_fill10, tx_half, !tx_full),
                    fifo_stat(LG4, rx_fill10, rx_half, !rx_empty)};
                PP_RX:    rdata_d = {12'h0, rxovf_q, 2'b0,
                                     rx_empty, 16'(rx_head)};
                PP_TX:    rdata_d = {12'h0, txovf_q, 1'b0,
                                     !tx_empty, tx_full, 16'(tx_fill)};
                default:  rdata_d = rdata_q;
            endcase
        end
    end

    // A clear written in the same clock as a drop wins.
    always_comb begin
        rxovf_d = rxovf_q;
        txovf_d = txovf_q;
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;
        if (rx_drop) rxovf_d = 1'b1;
        if (rx_wr && req_q.clrovf) rxovf_d = 1'b0;
        if (tx_drop) txovf_d = 1'b1;
        if (tx_wr && req_q.clrovf) txovf_d = 1'b0;
        if (su_wr) tmo_d = req_q.data;
        if (rx_clr || rx_push_ok || rx_pop)
            cnt_d = '0;
        else if (!rx_empty && cnt_q != '1)
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ack_q <= 1'b0;
            ack_q   <= 1'b0;
            req_q   <= '0;
            rdata_q <= '0;
            tmo_q   <= '0;
            cnt_q   <= '0;
            rxovf_q <= 1'b0;
            txovf_q <= 1'b0;
        end else begin
            r_ack_q <= stb;
            ack_q   <= r_ack_q;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
            rxovf_q <= rxovf_d;
            txovf_q <= txovf_d;
        end
    end

    assign wb.ack   = ack_q;
    assign wb.stall = 1'b0;
    assign wb.rdata = rdata_q;

    assign o_pp_busy    = rx_full;
    assign o_pp_stb     = !tx_empty;
    assign o_pp_data    = tx_head;
    assign o_rx_int     = !rx_empty;
    assign o_tx_int     = !tx_full;
    assign o_rxfifo_int = rx_half;
    assign o_txfifo_int = tx_half;
    assign o_rxto_int   = (tmo_q != '0) && !rx_empty
                          && (cnt_q >= tmo_q);

endmodule

// File: tb/tb_wbpport_gen.sv
// Self-checking bench for wbpport_gen (DW=8, depth 4): directed
// scenarios then random traffic against a queue-based reference.
module tb_wbpport_gen;

    localparam int DW  = 8;
    localparam int LG  = 2;
    localparam int DEP = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wbpport_gen_if wb();

    logic        b_stb, b_we;
    logic [1:0]  b_addr;
    logic [31:0] b_data;
    assign wb.cyc   = b_stb;
    assign wb.stb   = b_stb;
    assign wb.we    = b_we;
    assign wb.addr  = b_addr;
    assign wb.wdata = b_data;

    logic          pp_stb, pp_busy;
    logic [DW-1:0] pp_din;
    logic          o_busy, o_stb, o_rxi, o_txi;
    logic          o_rxf, o_txf, o_rxto;
    logic [DW-1:0] o_data;

    wbpport_gen #(.DW(DW), .LGFLEN(LG)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .wb           (wb),
        .i_pp_stb     (pp_stb),
        .i_pp_data    (pp_din),
        .o_pp_busy    (o_busy),
        .o_pp_stb     (o_stb),
        .o_pp_data    (o_data),
        .i_pp_busy    (pp_busy),
        .o_rx_int     (o_rxi),
        .o_tx_int     (o_txi),
        .o_rxfifo_int (o_rxf),
        .o_txfifo_int (o_txf),
        .o_rxto_int   (o_rxto)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    logic [7:0]  rxq[$];
    logic [7:0]  txq[$];
    bit          rxovf, txovf;
    int          tmo, cnt;
    bit          p_v, p_we;
    logic [1:0]  p_addr;
    logic [31:0] p_data;
    bit          m_ack, m_we;
    logic [31:0] m_data;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic int stat(input int fill, input bit half,
                                input bit flag);
        return (2 << 12) | (fill << 2) | (int'(half) << 1) | int'(flag);
    endfunction

    function automatic logic [31:0] readval(input logic [1:0] a);
        int rf = rxq.size();
        int tf = txq.size();
        case (a)
            2'd0: return 32'h2007_0000 | 32'(tmo);
            2'd1: return 32'((stat(tf, tf < DEP/2, tf != DEP) << 16)
                             | stat(rf, rf >= DEP/2, rf != 0));
            2'd2: return (32'(rxovf) << 19) | (32'(rf == 0) << 16)
                         | ((rf != 0) ? 32'(rxq[0]) : 32'h0);
            default: return (32'(txovf) << 19) | (32'(tf > 0) << 17)
                            | (32'(tf == DEP) << 16) | 32'(tf);
        endcase
    endfunction

    function automatic void model_edge();
        bit act, su, rxw, txw, rclr, tclr, rpop, tpop, tpush;
        bit rin, tin, was_ne;
        logic [31:0] d;
        if (rst) begin
            rxq.delete(); txq.delete();
            rxovf = 0; txovf = 0; tmo = 0; cnt = 0;
            p_v = 0; m_ack = 0; m_data = '0;
            return;
        end
        act = p_v; d = p_data;
        m_ack = act; m_we = p_we;
        if (act) m_data = readval(p_addr);
        su   = act && p_we && p_addr == 2'd0;
        rxw  = act && p_we && p_addr == 2'd2;
        txw  = act && p_we && p_addr == 2'd3;
        rclr = su || (rxw && d[16]);
        tclr = su || (txw && d[16]);
        rpop = act && !p_we && p_addr == 2'd2 && rxq.size() > 0;
        tpop = txq.size() > 0 && !pp_busy;
        tpush = txw && !d[16];
        was_ne = rxq.size() > 0;
        rin = 0;
        if (rclr) rxq.delete();
        else begin
            rin = pp_stb && (rxq.size() < DEP || rpop);
            if (pp_stb && !rin) rxovf = 1;
            if (rpop) void'(rxq.pop_front());
            if (rin) rxq.push_back(pp_din);
        end
        if (rxw && d[19]) rxovf = 0;
        if (tclr) txq.delete();
        else begin
            tin = tpush && (txq.size() < DEP || tpop);
            if (tpush && !tin) txovf = 1;
            if (tpop) void'(txq.pop_front());
            if (tin) txq.push_back(d[7:0]);
        end
        if (txw && d[19]) txovf = 0;
        if (su) tmo = int'(d[15:0]);
        if (rclr || rin || rpop) cnt = 0;
        else if (was_ne && cnt < 65535) cnt++;
        p_v = b_stb; p_we = b_we; p_addr = b_addr; p_data = b_data;
    endfunction

    function automatic logic [8:0] flags();
        return {o_busy, o_stb, o_rxi, o_txi, o_rxf, o_txf,
                o_rxto, wb.ack, wb.stall};
    endfunction

    task automatic check_outputs();
        int rf = rxq.size();
        int tf = txq.size();
        logic [8:0] e;
        e = {rf == DEP, tf > 0, rf > 0, tf < DEP, rf >= DEP/2,
             tf < DEP/2, tmo != 0 && rf > 0 && cnt >= tmo,
             m_ack, 1'b0};
        chk("flags", 32'(flags()), 32'(e));
        if (m_ack && !m_we) chk("rdata", wb.rdata, m_data);
        if (tf > 0) chk("pp_data", 32'(o_data), 32'(txq[0]));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic bus(input bit we, input logic [1:0] a,
                       input logic [31:0] d, output logic [31:0] r);
        b_stb = 1; b_we = we; b_addr = a; b_data = d;
        step();
        b_stb = 0;
        chk("ack_early", 32'(wb.ack), 32'd0);
        step();
        chk("ack_2clk", 32'(wb.ack), 32'd1);
        r = wb.rdata;
        step();
    endtask

    initial begin
        logic [31:0] r;
        int n;
        rst = 1; b_stb = 0; b_we = 0; b_addr = 0; b_data = 0;
        pp_stb = 0; pp_din = 0; pp_busy = 1;
        step(); step();
        chk("rst_flags", 32'(flags()), 32'h028);
        chk("rst_rdata", wb.rdata, 32'h0);
        rst = 0;
        step();

        // RX fill and overflow
        for (int i = 0; i < 5; i++) begin
            pp_stb = 1; pp_din = 8'(8'h11 + i);
            step();
            if (i == 3) chk("busy_at4", 32'(o_busy), 32'd1);
        end
        pp_stb = 0;
        step();
        for (int i = 0; i < 5; i++) begin
            bus(0, 2'd2, 32'h0, r);
            chk("rx_read", r, (i < 4) ? 32'h8_0011 + 32'(i)
                                      : 32'h9_0000);
        end
        bus(1, 2'd2, 32'h8_0000, r);
        bus(0, 2'd2, 32'h0, r);
        chk("rxovf_clr", r, 32'h1_0000);

        // TX held by busy sink
        bus(1, 2'd3, 32'hA5, r);
        for (int i = 0; i < 3; i++) begin
            chk("tx_hold", {23'h0, o_stb, o_data}, 32'h1A5);
            step();
        end
        pp_busy = 0;
        step();
        chk("tx_popped", 32'(o_stb), 32'd0);
        pp_busy = 1;

        // RX idle timeout
        bus(1, 2'd0, 32'd5, r);
        bus(0, 2'd0, 32'h0, r);
        chk("setup_rd", r, 32'h2007_0005);
        pp_stb = 1; pp_din = 8'h3C; step(); pp_stb = 0;
        n = 0;
        while (!o_rxto && n < 20) begin step(); n++; end
        chk("rxto_lat", n, 5);
        pp_stb = 1; pp_din = 8'h3D; step(); pp_stb = 0;
        chk("rxto_push", 32'(o_rxto), 32'd0);
        n = 0;
        while (!o_rxto && n < 20) begin step(); n++; end
        chk("rxto_lat2", n, 5);
        bus(0, 2'd2, 32'h0, r);
        chk("rxto_pop", 32'(o_rxto), 32'd0);

        // TX overflow and clears
        for (int i = 1; i <= 4; i++) bus(1, 2'd3, 32'(i), r);
        bus(1, 2'd3, 32'h99, r);
        bus(0, 2'd3, 32'h0, r);
        chk("txovf_set", r, 32'hB_0004);
        bus(1, 2'd3, 32'h8_0000, r);
        bus(0, 2'd3, 32'h0, r);
        chk("txovf_clr", r, 32'h3_0004);
        bus(1, 2'd0, 32'h0, r);
        bus(0, 2'd1, 32'h0, r);
        chk("fifo_stat", r, 32'h2003_2000);

        // Reset the clock after a bus stb
        pp_stb = 1; pp_din = 8'h55; step(); pp_stb = 0;
        bus(1, 2'd3, 32'h77, r);
        b_stb = 1; b_we = 0; b_addr = 2'd0; step();
        b_stb = 0; rst = 1; step();
        rst = 0;
        chk("rst_noack", 32'(flags()), 32'h028);
        step();
        chk("rst_noack2", 32'(flags()), 32'h028);
        chk("rst_rdata2", wb.rdata, 32'h0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            pp_stb  = 1'($urandom_range(0, 1));
            pp_din  = 8'($urandom);
            pp_busy = ($urandom_range(0, 2) == 0);
            b_stb   = ($urandom_range(0, 2) == 0);
            b_we    = 1'($urandom_range(0, 1));
            b_addr  = 2'($urandom_range(0, 3));
            b_data  = $urandom;
            if ($urandom_range(0, 7) != 0) b_data[16] = 1'b0;
            if (b_addr == 2'd0)
                b_data[15:0] = 16'($urandom_range(0, 12));
            step();
        end
        b_stb = 0; pp_stb = 0;
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
